// File: rtl/qea_host_loader_pkg.sv
// Shared types and helpers for the QEA host loader: FSM state encoding,
// control-word width and the qubit-count derived sizing functions.
package qea_host_loader_pkg;

  localparam int CTRL_W = 32;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_CTX   = 4'd1,
    S_LOAD_ST    = 4'd2,
    S_START      = 4'd3,
    S_RUN        = 4'd4,
    S_READ_ISSUE = 4'd5,
    S_READ_WAIT  = 4'd6,
    S_READ_OUT   = 4'd7,
    S_DONE       = 4'd8
  } state_e;

  // Number of STATE RAM words for a qubit count: 2^(qbit - log2(PE count)).
  function automatic logic [CTRL_W-1:0] word_count(input int qbit, input int pe_w);
    return 32'd1 << (qbit - pe_w);
  endfunction

  // A qubit count is usable only if it spans more than one PE word and the
  // resulting word count still fits in the STATE RAM address space.
  function automatic logic qbit_ok(input int qbit, input int pe_w, input int saw);
    return (qbit > pe_w) && (qbit <= pe_w + saw);
  endfunction

endpackage

// File: rtl/qea_host_loader_if.sv
// Host-side valid/ready streams of the QEA host loader: context words in,
// initial state words in, final state words out.
interface qea_host_loader_if #(
  parameter int CDW = 64,
  parameter int SW  = 256
) ();

  logic           ctx_valid;
  logic           ctx_ready;
  logic [CDW-1:0] ctx_data;
  logic           st_valid;
  logic           st_ready;
  logic [SW-1:0]  st_data;
  logic           res_valid;
  logic           res_ready;
  logic [SW-1:0]  res_data;

  modport master (
    output ctx_valid, ctx_data, st_valid, st_data, res_ready,
    input  ctx_ready, st_ready, res_valid, res_data
  );

  modport slave (
    input  ctx_valid, ctx_data, st_valid, st_data, res_ready,
    output ctx_ready, st_ready, res_valid, res_data
  );

endinterface

// File: rtl/qea_host_loader.sv
// QEA host loader: streams context and initial state into the accelerator's
// RAMs, starts it, times the run, then streams the final state back out.
// A single word counter is reused as load index, cycle counter and read index.
module qea_host_loader
  import qea_host_loader_pkg::*;
#(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 1 << PE_NUM_WIDTH,
  parameter int DATA_WIDTH       = 32,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int STATE_DATA_WIDTH = 2 * DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int CTX_DATA_WIDTH   = 64,
  parameter int CTX_ADDR_WIDTH   = 16,
  parameter int RD_LAT           = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [CTX_ADDR_WIDTH:0]              i_ins_num,
  qea_host_loader_if.slave                     host,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [CTX_ADDR_WIDTH-1:0]            o_ctx_addr,
  output logic [CTX_DATA_WIDTH-1:0]            o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_exec_cycles
);

  localparam int SW  = PE_NUM * STATE_DATA_WIDTH;
  localparam int CAW = CTX_ADDR_WIDTH;
  localparam int SAW = STATE_ADDR_WIDTH;
  localparam int MQW = MAX_QBIT_WIDTH;

  state_e              r_state;
  logic [CTRL_W-1:0]   r_cnt;
  logic [CTRL_W-1:0]   r_words_m1;
  logic [CAW:0]        r_ins;
  logic [7:0]          r_wait;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [31:0]         r_exec;
  logic                r_qea_start;
  logic [MQW-1:0]      r_qbit;
  logic                r_ctx_ready;
  logic                r_st_ready;
  logic                r_res_valid;
  logic [SW-1:0]       r_res_data;
  logic                r_ctx_en;
  logic                r_ctx_wea;
  logic [CAW-1:0]      r_ctx_addr;
  logic [CTX_DATA_WIDTH-1:0] r_ctx_data;
  logic                r_state_ena;
  logic                r_state_wea;
  logic [SAW-1:0]      r_state_addra;
  logic [SW-1:0]       r_state_dina;

  logic                w_qbit_ok;
  logic [CTRL_W-1:0]   w_words_m1;
  logic                w_ctx_hs;
  logic                w_st_hs;
  logic                w_res_hs;

  assign w_qbit_ok  = qbit_ok(int'(i_qbit_num), PE_NUM_WIDTH, SAW);
  assign w_words_m1 = word_count(int'(i_qbit_num), PE_NUM_WIDTH) - 32'd1;
  assign w_ctx_hs   = host.ctx_valid & r_ctx_ready;
  assign w_st_hs    = host.st_valid & r_st_ready;
  assign w_res_hs   = r_res_valid & host.res_ready;

  // Sequencer: load CTX, load STATE, start, time the run, read STATE back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 32'd0;
      r_words_m1    <= 32'd0;
      r_ins         <= (CAW+1)'(0);
      r_wait        <= 8'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_exec        <= 32'd0;
      r_qea_start   <= 1'b0;
      r_qbit        <= MQW'(0);
      r_ctx_ready   <= 1'b0;
      r_st_ready    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= SW'(0);
      r_ctx_en      <= 1'b0;
      r_ctx_wea     <= 1'b0;
      r_ctx_addr    <= CAW'(0);
      r_ctx_data    <= CTX_DATA_WIDTH'(0);
      r_state_ena   <= 1'b0;
      r_state_wea   <= 1'b0;
      r_state_addra <= SAW'(0);
      r_state_dina  <= SW'(0);
    end else begin
      // RAM strobes, start and done are single-cycle unless re-armed below.
      r_ctx_en    <= 1'b0;
      r_ctx_wea   <= 1'b0;
      r_state_ena <= 1'b0;
      r_state_wea <= 1'b0;
      r_qea_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            if (!w_qbit_ok) begin
              r_err <= 1'b1;
            end else begin
              r_err      <= 1'b0;
              r_busy     <= 1'b1;
              r_qbit     <= i_qbit_num;
              r_ins      <= i_ins_num;
              r_words_m1 <= w_words_m1;
              r_cnt      <= 32'd0;
              if (i_ins_num == (CAW+1)'(0)) begin
                r_st_ready <= 1'b1;
                r_state    <= S_LOAD_ST;
              end else begin
                r_ctx_ready <= 1'b1;
                r_state     <= S_LOAD_CTX;
              end
            end
          end
        end
        S_LOAD_CTX: begin
          if (w_ctx_hs) begin
            r_ctx_en   <= 1'b1;
            r_ctx_wea  <= 1'b1;
            r_ctx_addr <= r_cnt[CAW-1:0];
            r_ctx_data <= host.ctx_data;
            if ((r_cnt + 32'd1) == CTRL_W'(r_ins)) begin
              r_cnt       <= 32'd0;
              r_ctx_ready <= 1'b0;
              r_st_ready  <= 1'b1;
              r_state     <= S_LOAD_ST;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
        end
        S_LOAD_ST: begin
          if (w_st_hs) begin
            r_state_ena   <= 1'b1;
            r_state_wea   <= 1'b1;
            r_state_addra <= r_cnt[SAW-1:0];
            r_state_dina  <= host.st_data;
            if (r_cnt == r_words_m1) begin
              r_cnt      <= 32'd0;
              r_st_ready <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
        end
        S_START: begin
          // The last STATE write strobe is visible this cycle; start follows it.
          r_qea_start <= 1'b1;
          r_cnt       <= 32'd0;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          // r_cnt is 0 while start is high; a complete seen then is stale.
          if (i_qea_complete && (r_cnt != 32'd0)) begin
            r_exec        <= r_cnt;
            r_cnt         <= 32'd0;
            r_state_ena   <= 1'b1;
            r_state_addra <= SAW'(0);
            r_state       <= S_READ_ISSUE;
          end else if (r_cnt != 32'hFFFF_FFFF) begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_READ_ISSUE: begin
          r_wait  <= 8'd0;
          r_state <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          if (r_wait == 8'(RD_LAT - 1)) begin
            r_res_data  <= i_qea_state_dout;
            r_res_valid <= 1'b1;
            r_state     <= S_READ_OUT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_READ_OUT: begin
          if (w_res_hs) begin
            r_res_valid <= 1'b0;
            if (r_cnt == r_words_m1) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt         <= r_cnt + 32'd1;
              r_state_ena   <= 1'b1;
              r_state_addra <= r_cnt[SAW-1:0] + SAW'(1);
              r_state       <= S_READ_ISSUE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_ctx_ready <= 1'b0;
          r_st_ready  <= 1'b0;
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign host.ctx_ready = r_ctx_ready;
  assign host.st_ready  = r_st_ready;
  assign host.res_valid = r_res_valid;
  assign host.res_data  = r_res_data;
  assign o_qea_start    = r_qea_start;
  assign o_qbit_num     = r_qbit;
  assign o_ctx_en       = r_ctx_en;
  assign o_ctx_wea      = r_ctx_wea;
  assign o_ctx_addr     = r_ctx_addr;
  assign o_ctx_data     = r_ctx_data;
  assign o_state_ena    = r_state_ena;
  assign o_state_wea    = r_state_wea;
  assign o_state_addra  = r_state_addra;
  assign o_state_dina   = r_state_dina;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_exec_cycles  = r_exec;

endmodule

// File: tb/tb_qea_host_loader.sv
// Bench for qea_host_loader: directed jobs against a behavioural QEA (RAM that
// inverts its contents on completion, fixed run latency) and a scoreboard of
// what the host sent. A negedge monitor checks every strobe and result word.
module tb_qea_host_loader;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_go;
  logic [5:0]    i_qbit_num;
  logic [16:0]   i_ins_num;
  logic          o_qea_start;
  logic [5:0]    o_qbit_num;
  logic          o_ctx_en, o_ctx_wea;
  logic [15:0]   o_ctx_addr;
  logic [63:0]   o_ctx_data;
  logic          o_state_ena, o_state_wea;
  logic [15:0]   o_state_addra;
  logic [255:0]  o_state_dina;
  logic          i_qea_complete;
  logic [255:0]  i_qea_state_dout;
  logic          o_busy, o_done, o_err;
  logic [31:0]   o_exec_cycles;

  qea_host_loader_if hif ();

  qea_host_loader dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .host(hif), .o_qea_start(o_qea_start), .o_qbit_num(o_qbit_num),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .i_qea_complete(i_qea_complete),
    .i_qea_state_dout(i_qea_state_dout), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_exec_cycles(o_exec_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: what the host sends and where each stream has got to.
  logic [63:0]  exp_ctx [0:127];
  logic [255:0] exp_st  [0:15];
  int exp_ins, exp_words, qea_lat = 2;
  int ctx_idx, st_idx, rd_idx, res_idx;
  int ctx_wr_cnt = 0, st_wr_cnt = 0, start_cnt = 0, done_cnt = 0;
  int job_d0;
  bit run_flag = 0, prev_stall = 0, prev_hs = 0, prev_done = 0;
  logic [255:0] prev_data;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural QEA: STATE RAM with 1-cycle read, run lasts qea_lat cycles
  // after the start cycle, then every amplitude word is bit-inverted and
  // complete stays high until the next start.
  logic [255:0] qmem [0:15];
  logic         q_done;
  int           q_cnt;
  assign i_qea_complete = q_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_done <= 1'b0;
      q_cnt <= 0;
      i_qea_state_dout <= '0;
    end else begin
      if (o_state_ena && o_state_wea) qmem[o_state_addra[3:0]] <= o_state_dina;
      if (o_state_ena && !o_state_wea) i_qea_state_dout <= qmem[o_state_addra[3:0]];
      if (o_qea_start) begin
        q_cnt <= 1;
        q_done <= 1'b0;
      end else if (q_cnt != 0) begin
        if (q_cnt == qea_lat - 1) begin
          q_done <= 1'b1;
          q_cnt <= 0;
          for (int i = 0; i < 16; i++) qmem[i] <= ~qmem[i];
        end else begin
          q_cnt <= q_cnt + 1;
        end
      end
    end
  end

  // Monitor: checks every write, start, read, result and done against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_ctx_en) begin
        chk("ctx_wea", o_ctx_wea, 1);
        chk("ctx_in_range", ctx_idx < exp_ins, 1);
        chk("ctx_addr", o_ctx_addr, ctx_idx);
        chk("ctx_data", o_ctx_data, exp_ctx[ctx_idx & 127]);
        chk("ctx_wr_in_run", run_flag, 0);
        ctx_idx++;
        ctx_wr_cnt++;
      end
      if (o_state_ena && o_state_wea) begin
        chk("st_after_ctx", ctx_idx, exp_ins);
        chk("st_in_range", st_idx < exp_words, 1);
        chk("st_addr", o_state_addra, st_idx);
        chk("st_data", o_state_dina, exp_st[st_idx & 15]);
        chk("st_wr_in_run", run_flag, 0);
        st_idx++;
        st_wr_cnt++;
      end
      if (o_qea_start) begin
        chk("start_loads_done", (ctx_idx == exp_ins) && (st_idx == exp_words), 1);
        chk("start_no_strobe", o_ctx_en | o_state_ena, 0);
        run_flag = 1;
        start_cnt++;
      end
      if (o_state_ena && !o_state_wea) begin
        chk("read_after_complete", q_done, 1);
        chk("read_addr", o_state_addra, rd_idx);
        rd_idx++;
        run_flag = 0;
      end
      if (prev_stall) begin
        chk("res_valid_held", hif.res_valid, 1);
        chk("res_data_held", hif.res_data, prev_data);
      end
      if (hif.res_valid && hif.res_ready) begin
        chk("res_data", hif.res_data, ~exp_st[res_idx & 15]);
        res_idx++;
      end
      if (o_done) begin
        chk("done_after_last", prev_hs, 1);
        chk("done_pulse", prev_done, 0);
        chk("done_count", res_idx, exp_words);
        chk("done_exec", o_exec_cycles, qea_lat);
        done_cnt++;
      end
      prev_stall = hif.res_valid && !hif.res_ready;
      prev_hs    = hif.res_valid && hif.res_ready;
      prev_done  = o_done;
      prev_data  = hif.res_data;
    end else begin
      prev_stall = 0;
      prev_hs = 0;
      prev_done = 0;
      run_flag = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go(input int qbit, input int ins);
    i_go = 1'b1;
    i_qbit_num = 6'(qbit);
    i_ins_num = 17'(ins);
    cyc();
    i_go = 1'b0;
  endtask

  task automatic push_ctx(input logic [63:0] d, input int gap);
    int t;
    hif.ctx_valid = 1'b0;
    repeat (gap) cyc();
    hif.ctx_valid = 1'b1;
    hif.ctx_data = d;
    t = 0;
    while (!hif.ctx_ready && t < 200) begin cyc(); t++; end
    if (t >= 200) chk("ctx_ready_timeout", t, 0);
    cyc();
    hif.ctx_valid = 1'b0;
  endtask

  task automatic push_st(input logic [255:0] d, input int gap);
    int t;
    hif.st_valid = 1'b0;
    repeat (gap) cyc();
    hif.st_valid = 1'b1;
    hif.st_data = d;
    t = 0;
    while (!hif.st_ready && t < 200) begin cyc(); t++; end
    if (t >= 200) chk("st_ready_timeout", t, 0);
    cyc();
    hif.st_valid = 1'b0;
  endtask

  function automatic logic [255:0] rnd_w();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  // Fill the scoreboard, request a job and stream all context/state words.
  task automatic load_job(input int qbit, input int ins, input int lat, input bit bp, input bit go_busy);
    int nw;
    nw = 1 << (qbit - 2);
    exp_ins = ins;
    exp_words = nw;
    qea_lat = lat;
    for (int i = 0; i < ins; i++) exp_ctx[i] = {32'($urandom()), 32'($urandom())};
    for (int i = 0; i < nw; i++) exp_st[i] = rnd_w();
    ctx_idx = 0; st_idx = 0; rd_idx = 0; res_idx = 0;
    job_d0 = done_cnt;
    if (ins > 0) begin
      hif.st_valid = 1'b1;            // early state word must wait for the ctx phase
      hif.st_data = exp_st[0];
    end
    pulse_go(qbit, ins);
    chk("qbit_latched", o_qbit_num, qbit);
    chk("busy_after_go", o_busy, 1);
    for (int i = 0; i < ins; i++) push_ctx(exp_ctx[i], bp ? int'($urandom_range(0, 2)) : 0);
    for (int i = 0; i < nw; i++) begin
      push_st(exp_st[i], bp ? int'($urandom_range(0, 2)) : 0);
      if (go_busy && i == 1) begin
        pulse_go(4, 3);
        chk("go_while_busy", o_qbit_num, qbit);
      end
    end
  endtask

  // Drain results (optionally with random backpressure) until done or timeout.
  task automatic finish_job(input bit bp);
    int t = 0;
    while (done_cnt == job_d0 && t < 3000) begin
      hif.res_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      t++;
    end
    chk("done_seen", done_cnt - job_d0, 1);
    hif.res_ready = 1'b0;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; i_go = 1'b0; i_qbit_num = '0; i_ins_num = '0;
    hif.ctx_valid = 1'b0; hif.ctx_data = '0; hif.st_valid = 1'b0; hif.st_data = '0;
    hif.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {o_busy, o_done, o_err, o_qea_start, o_ctx_en, o_ctx_wea, o_state_ena,
                     o_state_wea, hif.ctx_ready, hif.st_ready, hif.res_valid}, 0);
    chk("rst_exec", o_exec_cycles, 0);
    chk("rst_addr_qbit", {o_ctx_addr, o_state_addra, o_qbit_num}, 0);
    chk("rst_ctx_data", o_ctx_data, 0);
    chk("rst_dina", o_state_dina, 0);
    chk("rst_res_data", hif.res_data, 0);
    rst_n = 1'b1;
    cyc();

    // 5 qubits, 101 ctx words, no backpressure, 37-cycle run.
    load_job(5, 101, 37, 0, 0);
    finish_job(0);
    chk("A_ctx_writes", ctx_wr_cnt, 101);
    chk("A_st_writes", st_wr_cnt, 8);
    chk("A_starts", start_cnt, 1);
    chk("A_results", res_idx, 8);
    chk("A_exec", o_exec_cycles, 37);
    chk("A_idle", o_busy, 0);

    // Backpressure everywhere plus an i_go while busy.
    load_job(5, 20, 12, 1, 1);
    finish_job(1);
    chk("B_ctx_writes", ctx_wr_cnt, 121);
    chk("B_st_writes", st_wr_cnt, 16);
    chk("B_exec", o_exec_cycles, 12);
    chk("B_qbit", o_qbit_num, 5);

    // Illegal qubit counts on both sides of the legal range.
    t = ctx_wr_cnt + st_wr_cnt + start_cnt;
    pulse_go(2, 5);
    repeat (5) cyc();
    chk("bad2_err", o_err, 1);
    chk("bad2_busy", {o_busy, hif.ctx_ready, hif.st_ready}, 0);
    chk("bad2_no_strobes", ctx_wr_cnt + st_wr_cnt + start_cnt, t);
    pulse_go(19, 5);
    cyc();
    chk("bad19_err", o_err, 1);
    chk("bad19_busy", o_busy, 0);

    // ins_num == 0 goes straight to state loading; error clears.
    load_job(3, 0, 5, 0, 0);
    chk("C_err_cleared", o_err, 0);
    finish_job(0);
    chk("C_ctx_writes", ctx_wr_cnt, 121);
    chk("C_st_writes", st_wr_cnt, 18);
    chk("C_exec", o_exec_cycles, 5);

    // Reset in the middle of a long run.
    load_job(4, 7, 300, 0, 0);
    t = 0;
    while (start_cnt < 4 && t < 50) begin cyc(); t++; end
    chk("D_started", start_cnt, 4);
    repeat (20) cyc();
    rst_n = 1'b0;
    #1;
    chk("D_rst_ctrl", {o_busy, o_done, o_qea_start, o_state_ena, hif.res_valid}, 0);
    chk("D_rst_exec", o_exec_cycles, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // A fresh job after the abort completes normally.
    load_job(4, 7, 9, 1, 0);
    finish_job(1);
    chk("E_exec", o_exec_cycles, 9);
    chk("E_results", res_idx, 4);
    chk("E_done_total", done_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
